id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register. Sits directly downstream of the register file.
//  - Captures decoded fields and register-file read data each cycle.
//  - Supplies write-back bypass and forces x0 to read as zero.
//  - Detects load-use hazards and inserts bubbles.
//  - Honours downstream hold (e.g. multi-cycle MUL/DIV) and flush (branch/jump redirect).
// PARAMETERS
//  XLEN    32  datapath width
//  CTRL_W  16  width of opaque execute-control bundle (ALU op, mux selects); not interpreted here
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, asynchronous, active-low
//  id_valid      in   1       decode slot holds a real instruction
//  id_ready      out  1       stage accepts decode slot this cycle; upstream advances only when 1
//  id_pc         in   XLEN    instruction PC
//  id_rs1_addr   in   5       source 1 index (same value driven to regfile addr1)
//  id_rs2_addr   in   5       source 2 index (same value driven to regfile addr2)
//  id_rd_addr    in   5       destination index
//  id_rs1_data   in   XLEN    regfile data1
//  id_rs2_data   in   XLEN    regfile data2
//  id_imm        in   XLEN    sign-extended immediate
//  id_uses_rs1   in   1       instruction reads rs1
//  id_uses_rs2   in   1       instruction reads rs2
//  id_is_load    in   1       instruction is a load
//  id_reg_write  in   1       instruction writes rd
//  id_ctrl       in   CTRL_W  execute-control bundle
//  wb_we         in   1       write-back enable (same net as regfile we)
//  wb_waddr      in   5       write-back index
//  wb_wd         in   XLEN    write-back data
//  ex_hold       in   1       execute cannot accept; freeze this stage
//  flush         in   1       squash stage contents (redirect)
//  ex_valid      out  1       execute slot valid
//  ex_pc, ex_imm              out  XLEN    registered copies
//  ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5  registered copies
//  ex_rs1_data, ex_rs2_data   out  XLEN    registered, bypassed operands
//  ex_is_load, ex_reg_write   out  1       registered copies, gated by ex_valid
//  ex_ctrl       out  CTRL_W  registered bundle
//  load_use_stall out 1       combinational hazard flag
// BEHAVIOUR
//  - Reset (rst=0): all ex_* outputs forced to 0 asynchronously, ex_valid=0. Applies mid-operation too.
//  - Operand select, per source s in {rs1, rs2}:
//    - addr==0 -> 0
//    - else wb_we && wb_waddr==addr -> wb_wd (regfile write lands a cycle late)
//    - else id data
//  - Hazard:
//    - load_use_stall = ex_valid & ex_is_load & ex_rd_addr!=0 & id_valid
//      & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
//  - id_ready = ~ex_hold & ~load_use_stall.
//  - Per-edge priority:
//    1. flush: ex_valid<=0; ex_is_load, ex_reg_write, ex_ctrl <= 0; other fields don't-care.
//    2. ex_hold: all fields held; if ex_valid, wb_we, wb_waddr!=0 and wb_waddr matches held
//       ex_rs1_addr/ex_rs2_addr, that operand <= wb_wd (stale-operand refresh).
//    3. load_use_stall: bubble; ex_valid<=0, ex_is_load/ex_reg_write/ex_ctrl <= 0.
//       Decode slot is not consumed.
//    4. Otherwise capture: ex_valid<=id_valid; all fields from id_*; operands via select above.
//       When id_valid=0, ex_is_load and ex_reg_write are forced to 0.
//  - Latency: one cycle, decode to execute. Bubble costs exactly one cycle per load-use.
//  - Simultaneous events:
//    - flush with hold or hazard -> flush wins.
//    - hold with hazard -> hold wins; hazard re-evaluated after hold releases.
// TESTING
//  1. Mid-op reset: ex_valid=1, drop rst between edges -> ex_valid=0 and all outputs 0
//     before the next edge.
//  2. Bypass: id_rs1_addr=5, id_rs1_data=0x11, wb_we=1, wb_waddr=5, wb_wd=0xDEAD ->
//     ex_rs1_data=0xDEAD. Same with addr 0 and wb_waddr 0 -> 0.
//  3. x0: id_rs2_addr=0, id_rs2_data=0xFFFFFFFF -> ex_rs2_data=0.
//  4. Load-use: ex holds load rd=7; id uses rs2=7 -> load_use_stall=1, id_ready=0,
//     next ex_valid=0; following edge captures the instruction.
//  5. Hold refresh: ex_rs1_addr=3, ex_rs1_data=1, ex_hold=1, wb writes x3=0x55 ->
//     ex_rs1_data=0x55; all other fields unchanged.
//  6. Priority: flush=1, ex_hold=1 and load_use_stall=1 together -> ex_valid=0, ex_ctrl=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register with write-back bypass,
// x0 forcing, load-use bubble insertion, hold with operand refresh, and flush.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_waddr,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic              ex_is_load,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_stall
);
    logic [XLEN-1:0] rs1_op, rs2_op;
    logic            refresh1, refresh2;

    // The regfile write lands a cycle late, so a same-cycle write-back must be bypassed.
    assign rs1_op = (id_rs1_addr == 5'd0) ? '0 :
                    (wb_we && wb_waddr == id_rs1_addr) ? wb_wd : id_rs1_data;
    assign rs2_op = (id_rs2_addr == 5'd0) ? '0 :
                    (wb_we && wb_waddr == id_rs2_addr) ? wb_wd : id_rs2_data;

    assign refresh1 = ex_valid && wb_we && wb_waddr != 5'd0 && wb_waddr == ex_rs1_addr;
    assign refresh2 = ex_valid && wb_we && wb_waddr != 5'd0 && wb_waddr == ex_rs2_addr;

    assign load_use_stall = ex_valid && ex_is_load && ex_rd_addr != 5'd0 && id_valid &&
                            ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                             (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    assign id_ready = !ex_hold && !load_use_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd_addr   <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_is_load   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_ctrl      <= '0;
        end else if (flush || (!ex_hold && load_use_stall)) begin
            ex_valid     <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_ctrl      <= '0;
        end else if (ex_hold) begin
            if (refresh1) ex_rs1_data <= wb_wd;
            if (refresh2) ex_rs2_data <= wb_wd;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_addr  <= id_rs1_addr;
            ex_rs2_addr  <= id_rs2_addr;
            ex_rd_addr   <= id_rd_addr;
            ex_rs1_data  <= rs1_op;
            ex_rs2_data  <= rs2_op;
            ex_is_load   <= id_valid && id_is_load;
            ex_reg_write <= id_valid && id_reg_write;
            ex_ctrl      <= id_ctrl;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, bypass, x0, load-use bubble,
// hold refresh, flush priority and asynchronous mid-operation reset.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, id_is_load, id_reg_write;
    logic [15:0] id_ctrl;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wd;
    logic        ex_hold, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic        ex_is_load, ex_reg_write;
    logic [15:0] ex_ctrl;
    logic        load_use_stall;
    int          n_checks = 0;
    int          n_fails  = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load),
        .id_reg_write(id_reg_write), .id_ctrl(id_ctrl), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wd(wb_wd), .ex_hold(ex_hold), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                         input logic ld, input logic [15:0] ctrl);
        id_valid = 1'b1; id_pc = pc; id_imm = pc + 32'h4;
        id_rs1_addr = r1; id_rs1_data = d1; id_uses_rs1 = 1'b1;
        id_rs2_addr = r2; id_rs2_data = d2; id_uses_rs2 = 1'b1;
        id_rd_addr = rd; id_is_load = ld; id_reg_write = 1'b1; id_ctrl = ctrl;
    endtask

    initial begin
        rst = 1'b0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_is_load = 0; id_reg_write = 0; id_ctrl = 0; wb_we = 0; wb_waddr = 0; wb_wd = 0;
        ex_hold = 0; flush = 0;
        #1;
        check("reset_valid", 32'(ex_valid), 32'd0);
        check("reset_pc", ex_pc, 32'd0);
        check("reset_ctrl", 32'(ex_ctrl), 32'd0);
        step();
        rst = 1'b1;

        issue(32'h100, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 5'd3, 1'b0, 16'h1234);
        step();
        check("cap_valid", 32'(ex_valid), 32'd1);
        check("cap_pc", ex_pc, 32'h100);
        check("cap_imm", ex_imm, 32'h104);
        check("cap_rs1", ex_rs1_data, 32'hAAAA);
        check("cap_rs2", ex_rs2_data, 32'hBBBB);
        check("cap_rd", 32'(ex_rd_addr), 32'd3);
        check("cap_ctrl", 32'(ex_ctrl), 32'h1234);
        check("cap_regwr", 32'(ex_reg_write), 32'd1);

        issue(32'h104, 5'd5, 32'h11, 5'd0, 32'hFFFFFFFF, 5'd6, 1'b0, 16'h1);
        wb_we = 1; wb_waddr = 5'd5; wb_wd = 32'hDEAD;
        step();
        check("bypass_rs1", ex_rs1_data, 32'hDEAD);
        check("x0_rs2", ex_rs2_data, 32'd0);

        issue(32'h108, 5'd0, 32'h11, 5'd2, 32'h22, 5'd6, 1'b0, 16'h2);
        wb_waddr = 5'd0;
        step();
        check("bypass_x0_rs1", ex_rs1_data, 32'd0);
        check("nobypass_rs2", ex_rs2_data, 32'h22);
        wb_we = 0;

        issue(32'h10C, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4, 1'b1, 16'h3);
        id_valid = 0;
        step();
        check("inval_valid", 32'(ex_valid), 32'd0);
        check("inval_load", 32'(ex_is_load), 32'd0);
        check("inval_regwr", 32'(ex_reg_write), 32'd0);

        issue(32'h1F0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd7, 1'b1, 16'h4);
        step();
        check("load_is_load", 32'(ex_is_load), 32'd1);
        issue(32'h200, 5'd1, 32'h1, 5'd7, 32'h77, 5'd8, 1'b0, 16'h5);
        id_uses_rs1 = 0;
        #1;
        check("lu_stall", 32'(load_use_stall), 32'd1);
        check("lu_ready", 32'(id_ready), 32'd0);
        id_uses_rs2 = 0;
        #1;
        check("lu_unused_src", 32'(load_use_stall), 32'd0);
        id_uses_rs2 = 1;
        step();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        check("lu_after_stall", 32'(load_use_stall), 32'd0);
        check("lu_after_ready", 32'(id_ready), 32'd1);
        step();
        check("lu_cap_valid", 32'(ex_valid), 32'd1);
        check("lu_cap_pc", ex_pc, 32'h200);
        check("lu_cap_rs2", ex_rs2_data, 32'h77);

        issue(32'h300, 5'd3, 32'h1, 5'd4, 32'h2, 5'd10, 1'b0, 16'hABCD);
        step();
        issue(32'h999, 5'd11, 32'h9, 5'd12, 32'h9, 5'd13, 1'b1, 16'h9999);
        ex_hold = 1; wb_we = 1; wb_waddr = 5'd3; wb_wd = 32'h55;
        #1;
        check("hold_ready", 32'(id_ready), 32'd0);
        step();
        check("hold_rs1", ex_rs1_data, 32'h55);
        check("hold_rs2", ex_rs2_data, 32'h2);
        check("hold_pc", ex_pc, 32'h300);
        check("hold_rd", 32'(ex_rd_addr), 32'd10);
        check("hold_ctrl", 32'(ex_ctrl), 32'hABCD);
        check("hold_valid", 32'(ex_valid), 32'd1);
        check("hold_load", 32'(ex_is_load), 32'd0);
        ex_hold = 0; wb_we = 0;

        issue(32'h400, 5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 1'b1, 16'h4444);
        step();
        issue(32'h404, 5'd9, 32'h1, 5'd2, 32'h2, 5'd8, 1'b0, 16'h5555);
        ex_hold = 1;
        #1;
        check("hh_stall", 32'(load_use_stall), 32'd1);
        step();
        check("hh_valid", 32'(ex_valid), 32'd1);
        check("hh_pc", ex_pc, 32'h400);
        ex_hold = 0;
        step();
        check("hh_bubble", 32'(ex_valid), 32'd0);
        step();
        check("hh_cap_pc", ex_pc, 32'h404);

        issue(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 1'b1, 16'h6666);
        step();
        issue(32'h504, 5'd9, 32'h1, 5'd2, 32'h2, 5'd8, 1'b0, 16'h7777);
        ex_hold = 1; flush = 1;
        #1;
        check("prio_stall", 32'(load_use_stall), 32'd1);
        step();
        check("prio_valid", 32'(ex_valid), 32'd0);
        check("prio_ctrl", 32'(ex_ctrl), 32'd0);
        check("prio_load", 32'(ex_is_load), 32'd0);
        ex_hold = 0; flush = 0;

        issue(32'h600, 5'd1, 32'h31, 5'd2, 32'h32, 5'd5, 1'b0, 16'h8888);
        step();
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ex_valid), 32'd0);
        check("mid_rst_pc", ex_pc, 32'd0);
        check("mid_rst_rs1", ex_rs1_data, 32'd0);
        check("mid_rst_ctrl", 32'(ex_ctrl), 32'd0);
        check("mid_rst_regwr", 32'(ex_reg_write), 32'd0);
        rst = 1'b1;
        step();
        check("post_rst_pc", ex_pc, 32'h600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
